// File: rtl/mac_kbd_responder.sv
// Keyboard side of the Mac Plus M0110 serial protocol: clocks in VIA commands, answers from a key FIFO.
// Optional: define MACKBD_INQ_TIMEOUT_EN to make Inquiry give up with a NULL (0x7B) after INQ_TIMEOUT ticks.
module mac_kbd_responder #(
  parameter int          CLK_HALF    = 1300,
  parameter int          INQ_TIMEOUT = 2000000,
  parameter logic [7:0]  MODEL_BYTE  = 8'h0B,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic       clk32,
  input  logic       _systemReset,
  input  logic       clk8_en_p,
  input  logic       mac_dat,
  output logic       kbd_clk,
  output logic       kbd_dat,
  input  logic [7:0] key_data,
  input  logic       key_strobe,
  output logic [7:0] cmd_data,
  output logic       cmd_strobe,
  output logic       busy,
  output logic       overflow
);

  localparam int TICK_MAX = (CLK_HALF > INQ_TIMEOUT) ? CLK_HALF : INQ_TIMEOUT;
  localparam int TICK_W   = $clog2(TICK_MAX + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

  localparam logic [7:0] CMD_INQUIRY = 8'h10;
  localparam logic [7:0] CMD_INSTANT = 8'h14;
  localparam logic [7:0] CMD_MODEL   = 8'h16;
  localparam logic [7:0] CMD_TEST    = 8'h36;
  localparam logic [7:0] REPLY_NULL  = 8'h7B;
  localparam logic [7:0] REPLY_TEST  = 8'h7D;

  typedef enum logic [2:0] {
    IDLE, RX_LO, RX_HI, DECODE, WAIT_KEY, WAIT_REL, TX_LO, TX_HI
  } state_t;

  state_t            state;
  logic [TICK_W-1:0] tickCnt;
  logic [2:0]        bitCnt;
  logic [7:0]        shReg;
  logic [7:0]        txReg;
  logic              halfDone;

  logic [7:0]        fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  fifoCount;
  logic              fifoFull;
  logic              fifoNonEmpty;
  logic              fifoPop;
  logic              pushOk;
  logic [7:0]        fifoHead;

  assign halfDone     = (tickCnt == TICK_W'(CLK_HALF - 1));
  assign fifoFull     = (fifoCount == CNT_W'(FIFO_DEPTH));
  assign fifoNonEmpty = (fifoCount != '0);
  assign fifoHead     = fifoMem[rdPtr];
  // A pop frees a slot in the same cycle, so a push into a full FIFO is still taken then.
  assign pushOk       = key_strobe && (!fifoFull || fifoPop);

  // The FSM only pops on a tick where it is about to latch fifoHead into txReg.
  always_comb begin
    fifoPop = 1'b0;
    if (clk8_en_p && fifoNonEmpty) begin
      if (state == DECODE && (shReg == CMD_INQUIRY || shReg == CMD_INSTANT))
        fifoPop = 1'b1;
      if (state == WAIT_KEY)
        fifoPop = 1'b1;
    end
  end

  always_ff @(posedge clk32) begin
    if (pushOk)
      fifoMem[wrPtr] <= key_data;
  end

  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
      overflow  <= 1'b0;
    end else begin
      if (pushOk)
        wrPtr <= wrPtr + 1'b1;
      if (fifoPop)
        rdPtr <= rdPtr + 1'b1;
      if (key_strobe && !pushOk)
        overflow <= 1'b1;
      case ({pushOk, fifoPop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      state      <= IDLE;
      tickCnt    <= '0;
      bitCnt     <= '0;
      shReg      <= '0;
      txReg      <= '0;
      kbd_clk    <= 1'b1;
      kbd_dat    <= 1'b1;
      cmd_data   <= '0;
      cmd_strobe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cmd_strobe <= 1'b0;
      if (clk8_en_p) begin
        case (state)
          IDLE: begin
            if (!mac_dat) begin
              state   <= RX_LO;
              kbd_clk <= 1'b0;
              bitCnt  <= '0;
              tickCnt <= '0;
              busy    <= 1'b1;
            end
          end
          RX_LO: begin
            if (halfDone) begin
              state   <= RX_HI;
              kbd_clk <= 1'b1;
              shReg   <= {shReg[6:0], mac_dat};
              tickCnt <= '0;
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
          RX_HI: begin
            if (halfDone) begin
              tickCnt <= '0;
              if (bitCnt == 3'd7) begin
                state <= DECODE;
              end else begin
                bitCnt  <= bitCnt + 1'b1;
                kbd_clk <= 1'b0;
                state   <= RX_LO;
              end
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
          DECODE: begin
            cmd_data   <= shReg;
            cmd_strobe <= 1'b1;
            tickCnt    <= '0;
            state      <= WAIT_REL;
            case (shReg)
              CMD_INQUIRY: begin
                if (fifoNonEmpty) txReg <= fifoHead;
                else              state <= WAIT_KEY;
              end
              CMD_INSTANT: txReg <= fifoNonEmpty ? fifoHead : REPLY_NULL;
              CMD_MODEL:   txReg <= MODEL_BYTE;
              CMD_TEST:    txReg <= REPLY_TEST;
              default:     txReg <= REPLY_NULL;
            endcase
          end
          WAIT_KEY: begin
            // A key landing on the timeout tick is still delivered.
            if (fifoNonEmpty) begin
              txReg <= fifoHead;
              state <= WAIT_REL;
            end
`ifdef MACKBD_INQ_TIMEOUT_EN
            else if (tickCnt == TICK_W'(INQ_TIMEOUT - 1)) begin
              txReg <= REPLY_NULL;
              state <= WAIT_REL;
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
`endif
          end
          WAIT_REL: begin
            if (mac_dat) begin
              state   <= TX_LO;
              kbd_clk <= 1'b0;
              kbd_dat <= txReg[7];
              txReg   <= {txReg[6:0], 1'b0};
              bitCnt  <= '0;
              tickCnt <= '0;
            end
          end
          TX_LO: begin
            if (halfDone) begin
              state   <= TX_HI;
              kbd_clk <= 1'b1;
              tickCnt <= '0;
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
          TX_HI: begin
            if (halfDone) begin
              tickCnt <= '0;
              if (bitCnt == 3'd7) begin
                kbd_dat <= 1'b1;
                busy    <= 1'b0;
                state   <= IDLE;
              end else begin
                bitCnt  <= bitCnt + 1'b1;
                kbd_clk <= 1'b0;
                kbd_dat <= txReg[7];
                txReg   <= {txReg[6:0], 1'b0};
                state   <= TX_LO;
              end
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
